ddr2_init_seq: RTL and testbench

DDR2_INIT_SEQ -- requirements
Module: ddr2_init_seq

---
 rtl/ddr2_init_seq.sv | 158 +++++++++++++++
 tb/tb_ddr2_init_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_init_seq
// Description : DDR2 power-up initialisation sequencer (CKE, PRE-ALL, EMRS,
//               MRS, REFRESH) driven by a single shared 24-bit down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_init_seq #(
    parameter int          T_PWRUP   = 40000,
    parameter int          T_CKE     = 80,
    parameter int          T_RP      = 3,
    parameter int          T_MRD     = 2,
    parameter int          T_RFC     = 26,
    parameter int          T_DLL     = 200,
    parameter logic [12:0] MR_VALUE  = 13'h0432,
    parameter logic [12:0] EMR_VALUE = 13'h0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        init_done,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [2:0]  ba,
    output logic [12:0] addr
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_PWRUP    = 3'd1;
    localparam logic [2:0] c_S_CKE_WAIT = 3'd2;
    localparam logic [2:0] c_S_CMD      = 3'd3;
    localparam logic [2:0] c_S_WAIT     = 3'd4;
    localparam logic [2:0] c_S_DONE     = 3'd5;

    localparam logic [3:0] c_CMD_DESEL = 4'b1111;
    localparam logic [3:0] c_CMD_NOP   = 4'b0111;
    localparam logic [3:0] c_CMD_PRE   = 4'b0010;
    localparam logic [3:0] c_CMD_REF   = 4'b0001;
    localparam logic [3:0] c_CMD_MRS   = 4'b0000;

    localparam logic [3:0]  c_LAST_IDX    = 4'd11;
    localparam logic [12:0] c_MR_DLL_RST  = MR_VALUE | 13'h0100;
    localparam logic [12:0] c_MR_NORM     = MR_VALUE & ~13'h0100;
    localparam logic [12:0] c_EMR_BASE    = EMR_VALUE & ~13'h0381;
    localparam logic [12:0] c_EMR_OCD     = c_EMR_BASE | 13'h0380;

    // The DLL lock time is folded into the last command's wait so that one
    // counter covers both the tMRD and tDLL constraints on init_done.
    localparam int c_DLL_ELAPSED = 3 * T_MRD + T_RP + 2 * T_RFC;
    localparam int c_FINAL_WAIT  = (T_DLL - c_DLL_ELAPSED > T_MRD) ?
                                   (T_DLL - c_DLL_ELAPSED) : T_MRD;

    if (T_PWRUP < 2 || T_PWRUP >= 2**24 || T_CKE < 2 || T_CKE >= 2**24 ||
        T_RP < 2 || T_RP >= 2**24 || T_MRD < 2 || T_MRD >= 2**24 ||
        T_RFC < 2 || T_RFC >= 2**24 || T_DLL < 2 || T_DLL >= 2**24) begin : g_param_check
        $fatal(1, "ddr2_init_seq: every T_* parameter must lie in [2, 2**24)");
    end

    logic [2:0]  r_state;
    logic [23:0] r_cnt;
    logic [3:0]  r_idx;
    logic [3:0]  r_cmd;

    logic [3:0]  w_cmd;
    logic [2:0]  w_ba;
    logic [12:0] w_addr;
    logic [23:0] w_wait;

    assign {cs_n, ras_n, cas_n, we_n} = r_cmd;

    always_comb begin
        w_cmd  = c_CMD_MRS;
        w_ba   = 3'd0;
        w_addr = 13'd0;
        w_wait = 24'(T_MRD);
        case (r_idx)
            4'd0, 4'd5: begin w_cmd = c_CMD_PRE; w_addr = 13'h0400; w_wait = 24'(T_RP); end
            4'd1:       w_ba = 3'd2;
            4'd2:       w_ba = 3'd3;
            4'd3:       begin w_ba = 3'd1; w_addr = c_EMR_BASE; end
            4'd4:       w_addr = c_MR_DLL_RST;
            4'd6, 4'd7: begin w_cmd = c_CMD_REF; w_wait = 24'(T_RFC); end
            4'd8:       w_addr = c_MR_NORM;
            4'd9:       begin w_ba = 3'd1; w_addr = c_EMR_OCD; end
            4'd10:      begin w_ba = 3'd1; w_addr = c_EMR_BASE; w_wait = 24'(c_FINAL_WAIT); end
            default:    w_cmd = c_CMD_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= 24'd0;
            r_idx     <= 4'd0;
            r_cmd     <= c_CMD_DESEL;
            ba        <= 3'd0;
            addr      <= 13'd0;
            cke       <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state <= c_S_PWRUP;
                        r_cnt   <= 24'(T_PWRUP - 1);
                        r_idx   <= 4'd0;
                        r_cmd   <= c_CMD_NOP;
                        busy    <= 1'b1;
                    end
                end
                c_S_PWRUP: begin
                    if (r_cnt == 24'd0) begin
                        r_state <= c_S_CKE_WAIT;
                        r_cnt   <= 24'(T_CKE - 1);
                        cke     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                c_S_CKE_WAIT, c_S_CMD, c_S_WAIT: begin
                    r_cmd <= c_CMD_NOP;
                    ba    <= 3'd0;
                    addr  <= 13'd0;
                    if (r_cnt != 24'd0) begin
                        r_cnt <= r_cnt - 24'd1;
                        if (r_state == c_S_CMD) begin
                            r_state <= c_S_WAIT;
                        end
                    end else if (r_idx == c_LAST_IDX) begin
                        r_state   <= c_S_DONE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        r_state <= c_S_CMD;
                        r_cmd   <= w_cmd;
                        ba      <= w_ba;
                        addr    <= w_addr;
                        r_cnt   <= w_wait - 24'd1;
                        r_idx   <= r_idx + 4'd1;
                    end
                end
                c_S_DONE: begin
                    r_cmd <= c_CMD_NOP;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr2_init_seq
// Description : Self-checking bench for ddr2_init_seq against an absolute
//               command-timeline model (two instances: tDLL short and long).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr2_init_seq;

    localparam int          P     = 10;
    localparam int          C     = 4;
    localparam int          RP    = 3;
    localparam int          MRD   = 2;
    localparam int          RFC   = 8;
    localparam int          DLL_A = 20;
    localparam int          DLL_B = 40;
    localparam logic [12:0] MRV   = 13'h1D32;
    localparam logic [12:0] EMRV  = 13'h1FFF;
    localparam logic [22:0] IDLE_VEC = {3'b000, 4'b1111, 3'd0, 13'd0};
    localparam int          RUN_LEN  = 76;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic        busy_a, done_a, cke_a, cs_n_a, ras_n_a, cas_n_a, we_n_a;
    logic [2:0]  ba_a;
    logic [12:0] addr_a;
    logic        busy_b, done_b, cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b;
    logic [2:0]  ba_b;
    logic [12:0] addr_b;
    logic [22:0] obs_a, obs_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr2_init_seq #(.T_PWRUP(P), .T_CKE(C), .T_RP(RP), .T_MRD(MRD), .T_RFC(RFC),
                    .T_DLL(DLL_A), .MR_VALUE(MRV), .EMR_VALUE(EMRV)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .init_done(done_a),
        .cke(cke_a), .cs_n(cs_n_a), .ras_n(ras_n_a), .cas_n(cas_n_a), .we_n(we_n_a),
        .ba(ba_a), .addr(addr_a));

    ddr2_init_seq #(.T_PWRUP(P), .T_CKE(C), .T_RP(RP), .T_MRD(MRD), .T_RFC(RFC),
                    .T_DLL(DLL_B), .MR_VALUE(MRV), .EMR_VALUE(EMRV)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .init_done(done_b),
        .cke(cke_b), .cs_n(cs_n_b), .ras_n(ras_n_b), .cas_n(cas_n_b), .we_n(we_n_b),
        .ba(ba_b), .addr(addr_b));

    assign obs_a = {busy_a, done_a, cke_a, cs_n_a, ras_n_a, cas_n_a, we_n_a, ba_a, addr_a};
    assign obs_b = {busy_b, done_b, cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b, ba_b, addr_b};

    // Expected {busy, init_done, cke, cmd, ba, addr} at cycle k after start.
    function automatic logic [22:0] exp_vec(input int k, input int dll);
        int t[11];
        int w[10];
        int done_t;
        logic [3:0]  cmd;
        logic [2:0]  b;
        logic [12:0] a;
        logic [12:0] emr;
        logic [12:0] mr;
        w = '{RP, MRD, MRD, MRD, MRD, RP, RFC, RFC, MRD, MRD};
        t[0] = P + C;
        for (int i = 1; i < 11; i++) t[i] = t[i-1] + w[i-1];
        done_t = (t[10] + MRD > t[4] + dll) ? t[10] + MRD : t[4] + dll;
        if (k >= done_t) return {3'b011, 4'b0111, 3'd0, 13'd0};
        cmd = 4'b0111; b = 3'd0; a = 13'd0;
        emr = EMRV; emr[9:7] = 3'b000; emr[0] = 1'b0;
        mr  = MRV;
        for (int i = 0; i < 11; i++) begin
            if (k == t[i]) begin
                cmd = 4'b0000;
                case (i)
                    0, 5:  begin cmd = 4'b0010; a = 13'h0400; end
                    1:     b = 3'd2;
                    2:     b = 3'd3;
                    3:     begin b = 3'd1; a = emr; end
                    4:     begin mr[8] = 1'b1; a = mr; end
                    6, 7:  cmd = 4'b0001;
                    8:     begin mr[8] = 1'b0; a = mr; end
                    9:     begin b = 3'd1; emr[9:7] = 3'b111; a = emr; end
                    default: begin b = 3'd1; a = emr; end
                endcase
            end
        end
        return {1'b1, 1'b0, (k >= P), cmd, b, a};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        int gap;
        do_reset();
        checks += 2;
        if (obs_a !== IDLE_VEC) begin
            errors++; $display("FAIL reset_a: got %h expected %h", obs_a, IDLE_VEC);
        end
        if (obs_b !== IDLE_VEC) begin
            errors++; $display("FAIL reset_b: got %h expected %h", obs_b, IDLE_VEC);
        end
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        gap = $urandom_range(3, 8);
        for (int i = 0; i < gap; i++) begin
            checks++;
            if (obs_a !== IDLE_VEC) begin
                errors++; $display("FAIL rst_beats_start: cycle %0d got %h expected %h", i, obs_a, IDLE_VEC);
            end
            tick();
        end
    endtask

    task automatic test_nominal;
        int gap;
        int ncmd_a;
        int ncmd_b;
        do_reset();
        gap = $urandom_range(1, 10);
        for (int i = 0; i < gap; i++) begin
            checks++;
            if (obs_a !== IDLE_VEC || obs_b !== IDLE_VEC) begin
                errors++; $display("FAIL idle_hold: got %h/%h expected %h", obs_a, obs_b, IDLE_VEC);
            end
            tick();
        end
        pulse_start();
        ncmd_a = 0;
        ncmd_b = 0;
        for (int k = 0; k < RUN_LEN; k++) begin
            checks += 2;
            if (obs_a !== exp_vec(k, DLL_A)) begin
                errors++; $display("FAIL nominal_a: cycle %0d got %h expected %h", k, obs_a, exp_vec(k, DLL_A));
            end
            if (obs_b !== exp_vec(k, DLL_B)) begin
                errors++; $display("FAIL nominal_b: cycle %0d got %h expected %h", k, obs_b, exp_vec(k, DLL_B));
            end
            if (obs_a[19:16] !== 4'b0111) ncmd_a++;
            if (obs_b[19:16] !== 4'b0111) ncmd_b++;
            tick();
        end
        checks += 2;
        if (ncmd_a != 11) begin
            errors++; $display("FAIL cmd_count_a: got %0d expected 11", ncmd_a);
        end
        if (ncmd_b != 11) begin
            errors++; $display("FAIL cmd_count_b: got %0d expected 11", ncmd_b);
        end
    endtask

    task automatic test_start_ignored;
        do_reset();
        pulse_start();
        for (int k = 0; k < RUN_LEN; k++) begin
            checks += 2;
            if (obs_a !== exp_vec(k, DLL_A)) begin
                errors++; $display("FAIL restart_a: cycle %0d got %h expected %h", k, obs_a, exp_vec(k, DLL_A));
            end
            if (obs_b !== exp_vec(k, DLL_B)) begin
                errors++; $display("FAIL restart_b: cycle %0d got %h expected %h", k, obs_b, exp_vec(k, DLL_B));
            end
            start = (k == 5 || k == 20 || k == 66 || $urandom_range(0, 5) == 0);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        int r;
        int gap;
        for (int trial = 0; trial < 3; trial++) begin
            r = (trial == 0) ? 30 : int'($urandom_range(1, 60));
            do_reset();
            pulse_start();
            for (int k = 0; k < r; k++) tick();
            rst = 1'b1;
            tick();
            checks += 2;
            if (obs_a !== IDLE_VEC) begin
                errors++; $display("FAIL abort_a: rst at %0d got %h expected %h", r, obs_a, IDLE_VEC);
            end
            if (obs_b !== IDLE_VEC) begin
                errors++; $display("FAIL abort_b: rst at %0d got %h expected %h", r, obs_b, IDLE_VEC);
            end
            rst = 1'b0;
            gap = $urandom_range(1, 8);
            for (int i = 0; i < gap; i++) begin
                tick();
                checks++;
                if (obs_a !== IDLE_VEC) begin
                    errors++; $display("FAIL abort_idle: got %h expected %h", obs_a, IDLE_VEC);
                end
            end
            pulse_start();
            for (int k = 0; k < RUN_LEN; k++) begin
                checks++;
                if (obs_a !== exp_vec(k, DLL_A)) begin
                    errors++; $display("FAIL rerun_a: cycle %0d got %h expected %h", k, obs_a, exp_vec(k, DLL_A));
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
